// File: rtl/arb_2x1_rr_if.sv
// Request/grant bundle between two requesters and the round-robin arbiter.
// The slave side is the arbiter; the master side is the requester pair.
interface arb_2x1_rr_if;
  logic req_a;
  logic req_b;
  logic grant_a;
  logic grant_b;
  logic select;
  logic busy;

  modport master (output req_a, req_b, input grant_a, grant_b, select, busy);
  modport slave  (input req_a, req_b, output grant_a, grant_b, select, busy);
endinterface

// File: rtl/arb_2x1_rr.sv
// Two-way round-robin arbiter with an optional hold limit.
// Grants, busy and select are all registered; select drives mux_2x1_beh (1 = A).
module arb_2x1_rr #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input logic         clock,
  input logic         reset_b,
  arb_2x1_rr_if.slave arb
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_A = 2'd1;
  localparam logic [1:0] GNT_B = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
  localparam bit               LIMIT_EN  = (MAX_HOLD != 0);

  logic [1:0]       state, nxt;
  logic [CNT_W-1:0] cnt;
  logic             last_a;
  logic             expire;

  // >= rather than == so an owner whose count ran past the limit while
  // uncontended still yields as soon as the other side shows up.
  assign expire = LIMIT_EN && (cnt >= HOLD_LAST);

  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (arb.req_a && arb.req_b) nxt = last_a ? GNT_B : GNT_A;
        else if (arb.req_a)         nxt = GNT_A;
        else if (arb.req_b)         nxt = GNT_B;
      end
      GNT_A: begin
        if (arb.req_b && (!arb.req_a || expire)) nxt = GNT_B;
        else if (!arb.req_a)                     nxt = IDLE;
      end
      GNT_B: begin
        if (arb.req_a && (!arb.req_b || expire)) nxt = GNT_A;
        else if (!arb.req_b)                     nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state       <= IDLE;
      cnt         <= '0;
      last_a      <= 1'b0;
      arb.grant_a <= 1'b0;
      arb.grant_b <= 1'b0;
      arb.busy    <= 1'b0;
      arb.select  <= 1'b0;
    end else begin
      state       <= nxt;
      arb.grant_a <= (nxt == GNT_A);
      arb.grant_b <= (nxt == GNT_B);
      arb.busy    <= (nxt != IDLE);
      // IDLE keeps the previous select so the downstream mux stays quiet
      if (nxt == GNT_A)      arb.select <= 1'b1;
      else if (nxt == GNT_B) arb.select <= 1'b0;

      if (nxt != state)                        cnt <= '0;
      else if (state != IDLE && cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);

      if (nxt != state && nxt == GNT_A)      last_a <= 1'b1;
      else if (nxt != state && nxt == GNT_B) last_a <= 1'b0;
    end
  end
endmodule

// File: tb/tb_arb_2x1_rr.sv
// Directed bench for arb_2x1_rr: one instance with MAX_HOLD=8, one unlimited.
// Both share clock, reset and request lines.
module tb_arb_2x1_rr;
  logic clock;
  logic reset_b;
  int   total;
  int   bad;

  arb_2x1_rr_if ifc8 ();
  arb_2x1_rr_if ifc0 ();

  assign ifc0.req_a = ifc8.req_a;
  assign ifc0.req_b = ifc8.req_b;

  arb_2x1_rr #(.MAX_HOLD(8), .CNT_W(4)) dut8 (.clock(clock), .reset_b(reset_b), .arb(ifc8));
  arb_2x1_rr #(.MAX_HOLD(0), .CNT_W(4)) dut0 (.clock(clock), .reset_b(reset_b), .arb(ifc0));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    ifc8.req_a = 1'b0;
    ifc8.req_b = 1'b0;
    reset_b    = 1'b0;
    step();
    reset_b = 1'b1;
  endtask

  task automatic test_reset();
    ifc8.req_a = 1'b0;
    ifc8.req_b = 1'b0;
    reset_b    = 1'b0;
    #1;
    total++;
    if ({ifc8.grant_a, ifc8.grant_b, ifc8.busy, ifc8.select} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_values got=%b want=0000", {ifc8.grant_a, ifc8.grant_b, ifc8.busy, ifc8.select});
    end
    step();
    reset_b = 1'b1;
    step();
    step();
    total++;
    if ({ifc8.grant_a, ifc8.grant_b, ifc8.busy, ifc8.select} !== 4'b0000) begin
      bad++;
      $display("FAIL idle_after_reset got=%b want=0000", {ifc8.grant_a, ifc8.grant_b, ifc8.busy, ifc8.select});
    end
    ifc8.req_a = 1'b1;
    step();
    step();
    total++;
    if ({ifc8.grant_a, ifc8.busy, ifc8.select} !== 3'b111) begin
      bad++;
      $display("FAIL grant_before_async_reset got=%b want=111", {ifc8.grant_a, ifc8.busy, ifc8.select});
    end
    #2 reset_b = 1'b0;
    #1;
    total++;
    if ({ifc8.grant_a, ifc8.grant_b, ifc8.busy, ifc8.select} !== 4'b0000) begin
      bad++;
      $display("FAIL async_reset_mid_grant got=%b want=0000", {ifc8.grant_a, ifc8.grant_b, ifc8.busy, ifc8.select});
    end
    ifc8.req_a = 1'b0;
    step();
    reset_b = 1'b1;
    step();
    step();
    total++;
    if ({ifc8.grant_a, ifc8.grant_b, ifc8.busy} !== 3'b000) begin
      bad++;
      $display("FAIL idle_after_release got=%b want=000", {ifc8.grant_a, ifc8.grant_b, ifc8.busy});
    end
  endtask

  task automatic test_single();
    apply_reset();
    ifc8.req_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if ({ifc8.grant_a, ifc8.grant_b, ifc8.busy, ifc8.select} !== 4'b1011) begin
        bad++;
        $display("FAIL single_grant cyc=%0d got=%b want=1011", i, {ifc8.grant_a, ifc8.grant_b, ifc8.busy, ifc8.select});
      end
    end
    ifc8.req_a = 1'b0;
    step();
    total++;
    if ({ifc8.grant_a, ifc8.grant_b, ifc8.busy, ifc8.select} !== 4'b0001) begin
      bad++;
      $display("FAIL single_release got=%b want=0001", {ifc8.grant_a, ifc8.grant_b, ifc8.busy, ifc8.select});
    end
  endtask

  task automatic test_tie();
    apply_reset();
    ifc8.req_a = 1'b1;
    ifc8.req_b = 1'b1;
    step();
    total++;
    if ({ifc8.grant_a, ifc8.grant_b, ifc8.select} !== 3'b101) begin
      bad++;
      $display("FAIL tie_first_a got=%b want=101", {ifc8.grant_a, ifc8.grant_b, ifc8.select});
    end
    step();
    ifc8.req_a = 1'b0;
    step();
    total++;
    if ({ifc8.grant_a, ifc8.grant_b, ifc8.busy, ifc8.select} !== 4'b0110) begin
      bad++;
      $display("FAIL handoff_to_b got=%b want=0110", {ifc8.grant_a, ifc8.grant_b, ifc8.busy, ifc8.select});
    end
    ifc8.req_b = 1'b0;
    step();
    total++;
    if ({ifc8.grant_a, ifc8.grant_b, ifc8.busy, ifc8.select} !== 4'b0000) begin
      bad++;
      $display("FAIL idle_keeps_sel_b got=%b want=0000", {ifc8.grant_a, ifc8.grant_b, ifc8.busy, ifc8.select});
    end
    // A served alone, then a tie from IDLE must go to B
    ifc8.req_a = 1'b1;
    step();
    ifc8.req_a = 1'b0;
    step();
    ifc8.req_a = 1'b1;
    ifc8.req_b = 1'b1;
    step();
    total++;
    if ({ifc8.grant_a, ifc8.grant_b, ifc8.select} !== 3'b010) begin
      bad++;
      $display("FAIL tie_after_a_goes_b got=%b want=010", {ifc8.grant_a, ifc8.grant_b, ifc8.select});
    end
  endtask

  task automatic test_rotation();
    logic exp_a;
    apply_reset();
    ifc8.req_a = 1'b1;
    ifc8.req_b = 1'b1;
    for (int k = 0; k < 34; k++) begin
      step();
      exp_a = (((k / 8) % 2) == 0);
      total++;
      if ({ifc8.grant_a, ifc8.grant_b, ifc8.select} !== {exp_a, ~exp_a, exp_a}) begin
        bad++;
        $display("FAIL rotation cyc=%0d got=%b want=%b", k, {ifc8.grant_a, ifc8.grant_b, ifc8.select}, {exp_a, ~exp_a, exp_a});
      end
    end
  endtask

  task automatic test_no_contention();
    apply_reset();
    ifc8.req_a = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      total++;
      if ({ifc8.grant_a, ifc8.grant_b, ifc8.busy} !== 3'b101) begin
        bad++;
        $display("FAIL long_hold cyc=%0d got=%b want=101", k, {ifc8.grant_a, ifc8.grant_b, ifc8.busy});
      end
    end
  endtask

  task automatic test_unlimited();
    apply_reset();
    ifc8.req_a = 1'b1;
    ifc8.req_b = 1'b1;
    for (int k = 0; k < 30; k++) begin
      step();
      total++;
      if ({ifc0.grant_a, ifc0.grant_b} !== 2'b10) begin
        bad++;
        $display("FAIL unlimited_hold cyc=%0d got=%b want=10", k, {ifc0.grant_a, ifc0.grant_b});
      end
    end
    ifc8.req_a = 1'b0;
    step();
    total++;
    if ({ifc0.grant_a, ifc0.grant_b, ifc0.select} !== 3'b010) begin
      bad++;
      $display("FAIL unlimited_release got=%b want=010", {ifc0.grant_a, ifc0.grant_b, ifc0.select});
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_tie();
    test_rotation();
    test_no_contention();
    test_unlimited();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
